// File: rtl/key_g_function_if.sv
// Handshake bundle between the AES-128 g-word generator and the key-word expansion stage.
interface key_g_function_if;
  logic         start;
  logic [127:0] key_in;
  logic         next_key_valid;
  logic [127:0] next_key;
  logic [127:0] roundkey;
  logic [31:0]  g;
  logic         g_valid;
  logic [3:0]   round;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, next_key_valid, next_key,
    input  roundkey, g, g_valid, round, busy, done
  );

  modport slave (
    input  start, key_in, next_key_valid, next_key,
    output roundkey, g, g_valid, round, busy, done
  );
endinterface

// File: rtl/key_g_function.sv
// AES-128 key-schedule g-word generator: RotWord + SubWord (one shared S-box, one byte
// per cycle) + Rcon, sequencing ten rounds with the downstream word-expansion stage.
module key_g_function #(
  parameter int NROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  key_g_function_if.slave   kif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] rk_q, rk_d;
  logic [31:0]  g_q, g_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   sub_in_s;
  logic [7:0]   sub_out_s;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    case (x)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // RotWord folded into the byte pick: cnt 0..3 selects W3 bytes 2,1,0,3.
  always_comb begin
    case (cnt_q)
      2'd0:    sub_in_s = rk_q[23:16];
      2'd1:    sub_in_s = rk_q[15:8];
      2'd2:    sub_in_s = rk_q[7:0];
      default: sub_in_s = rk_q[31:24];
    endcase
    sub_out_s = sbox(sub_in_s) ^ ((cnt_q == 2'd0) ? rcon_q : 8'h00);
  end

  // Next-state and datapath update for the round sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    rk_d    = rk_q;
    g_d     = g_q;
    round_d = round_q;
    case (state_q)
      ST_IDLE: begin
        if (kif.start) begin
          rk_d    = kif.key_in;
          round_d = 4'd1;
          rcon_d  = 8'h01;
          cnt_d   = 2'd0;
          state_d = ST_SUB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SUB: begin
        g_d[(5'd24 - {cnt_q, 3'b000}) +: 8] = sub_out_s;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_SUB;
        end
      end
      ST_WAIT: begin
        if (kif.next_key_valid) begin
          rk_d = kif.next_key;
          if (round_q < LAST_ROUND) begin
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
            cnt_d   = 2'd0;
            state_d = ST_SUB;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      rcon_q  <= 8'h01;
      rk_q    <= 128'd0;
      g_q     <= 32'd0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      rk_q    <= rk_d;
      g_q     <= g_d;
      round_q <= round_d;
    end
  end

  assign kif.roundkey = rk_q;
  assign kif.g        = g_q;
  assign kif.round    = round_q;
  assign kif.g_valid  = (state_q == ST_WAIT);
  assign kif.busy     = (state_q != ST_IDLE);
  assign kif.done     = (state_q == ST_DONE);

endmodule

// File: doc/key_g_function.md
# key_g_function

Generates the AES-128 g-word (RotWord, SubWord, Rcon XOR) for each of the 10 key-expansion rounds. It holds the current round key and sequences the rounds. It sits directly upstream of the key-word expansion stage: it presents `roundkey` and `g` to that stage, then accepts the expanded key back as the seed for the next round. SubWord uses a single shared forward S-box, processed one byte per cycle.

## Interface
Parameters:
- `NROUNDS`, default 10: number of key-expansion rounds. Fixed at 10 for AES-128.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  load `key_in` and begin expansion; sampled only in IDLE
- `key_in`  in  128  cipher key; W0 = [127:96] … W3 = [31:0]
- `next_key_valid`  in  1  downstream has produced the next round key; sampled only in WAIT
- `next_key`  in  128  expanded round key {Wout1, Wout2, Wout3, Wout4}
- `roundkey`  out  128  current round key (key r-1 during round r)
- `g`  out  32  g-word for the current round
- `g_valid`  out  1  `g` and `roundkey` are stable and consistent
- `round`  out  4  current round number, 1..10; 0 when idle after reset
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse after round 10's key is accepted

## Operation
- Input word: W3 = `roundkey[31:0]`.
- RotWord bytes, processed in this order:
  - b0 = W3[23:16]
  - b1 = W3[15:8]
  - b2 = W3[7:0]
  - b3 = W3[31:24]
- Output: `g` = {S(b0)^rcon, S(b1), S(b2), S(b3)}, where S is the standard AES forward S-box, implemented as an internal 256-entry case ROM.
- Rcon register:
  - Reset and load value: 8'h01.
  - Advances by xtime: {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - Sequence: 01 02 04 08 10 20 40 80 1B 36.

FSM states:
- **IDLE**:
  - `busy`=0.
  - On `start`: rk_reg←`key_in`, round←1, rcon←01, cnt←0, go to SUB.
- **SUB**:
  - Each cycle, g_reg byte[cnt]←S(b_cnt), with rcon XOR applied to byte 0.
  - cnt increments 0→3; at cnt=3, go to WAIT.
  - Takes exactly 4 cycles.
- **WAIT**:
  - `g_valid`=1; `g`, `roundkey`, `round` held stable.
  - On `next_key_valid` with round<10: rk_reg←`next_key`, round+1, rcon←xtime(rcon), cnt←0, go to SUB.
  - On `next_key_valid` with round=10: rk_reg←`next_key`, go to DONE.
- **DONE**:
  - `done`=1 for one cycle.
  - Go to IDLE. `roundkey` keeps the round-10 key and `round` stays at 10 until the next `start`.

Rules:
- `start` outside IDLE is ignored.
- `next_key_valid` outside WAIT is ignored.
- `start` and `next_key_valid` asserted together are resolved by state; they never conflict.
- `g` retains its last value outside WAIT, but is valid only while `g_valid`=1.
- Reset outputs: `roundkey`=0, `g`=0, `g_valid`=0, `round`=0, `busy`=0, `done`=0; state IDLE, cnt=0, rcon=01.
- Reset asserted mid-operation aborts immediately (asynchronous) and restores all reset values. No partial round completes.

## Timing
- `start` sampled at edge E0 → SUB occupies E1..E4 → `g_valid` high from after E4 (5 cycles start-to-valid).
- `next_key_valid` sampled at edge Ek in WAIT → `g_valid` low after Ek and high again after Ek+4.
- Minimum round period: 5 cycles, if downstream answers in the first WAIT cycle.
- Full expansion: 10 rounds × (4 + WAIT duration) + 1 DONE cycle.
- `g` and `roundkey` are registered outputs; there is no combinational path from any input to them.
- `g_valid` and `busy` are decoded from registered state only.
- `done` is high exactly one cycle, in DONE. `busy`=1 during that cycle and drops the cycle after.

## Test plan
1. Reset, then `start` with `key_in`=2b7e151628aed2a6abf7158809cf4f3c → `g_valid` rises 5 cycles later with `g`=8b84eb01, `round`=1, `roundkey`=`key_in`.
2. From scenario 1, hold WAIT for 3 extra cycles → outputs unchanged. Then `next_key`=a0fafe1788542cb123a339392a6c7605 with `next_key_valid` → after 4 cycles `g`=52386be5, `round`=2.
3. Full loop with a reference model returning correct FIPS-197 keys → `g` matches every round. Rcon sequence hits 1B at round 9 and 36 at round 10. `done` pulses once, and final `roundkey`=d014f9a8c9ee2589e13f0cc8b6630ca6.
4. Pulse `start` during SUB and during WAIT, and pulse `next_key_valid` during SUB → no state change and no output disturbance.
5. Deassert `rst_n` in the middle of SUB during round 4 → all outputs return to reset values immediately. A new `start` restarts from round 1 with rcon=01.
6. `start` asserted in the same cycle as `done` is high → ignored. `start` one cycle later → accepted.
